mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 12, data-RAM address width.
REQ-002 Parameter DATA_W, 8, data-RAM word width.
REQ-003 Parameter MAX_LOCK, 8, max consecutive host grants under host_lock_i (1..255).
REQ-004 One clock; reset is asynchronous and active-low; ports clk_i and rst_ni.
REQ-005 clk_i  in  1  clock, all state on rising edge.
REQ-006 rst_ni  in  1  async active-low reset.
REQ-007 cpu_req_i / cpu_we_i  in  1/1  CPU access request / write-not-read.
REQ-008 cpu_addr_i / cpu_wdata_i  in  ADDR_W/DATA_W  CPU address / write data.
REQ-009 cpu_gnt_o / cpu_rvalid_o  out  1/1  CPU grant this cycle / CPU read data valid.
REQ-010 cpu_rdata_o  out  DATA_W  CPU read data.
REQ-011 host_req_i, host_we_i, host_addr_i, host_wdata_i  in  1,1,ADDR_W,DATA_W  debug/loader port, same meaning as CPU.
REQ-012 host_lock_i  in  1  host requests back-to-back ownership.
REQ-013 host_gnt_o, host_rvalid_o, host_rdata_o  out  1,1,DATA_W  host grant / valid / data.
REQ-014 mem_ren_o, mem_wen_o, mem_addr_o, mem_din_o  out  1,1,ADDR_W,DATA_W  RAM port.
REQ-015 mem_dout_i  in  DATA_W  RAM read data, valid one cycle after mem_ren_o.
REQ-016 conflict_cnt_o  out  16  arbitration-conflict count.

Function
REQ-017 Grant is combinational from current requests and registered state; at most one of cpu_gnt_o/host_gnt_o high per cycle.
REQ-018 The granted port's addr/wdata/we drive mem_*; mem_ren_o = gnt & ~we, mem_wen_o = gnt & we; with no grant, mem_ren_o = mem_wen_o = 0 and mem_addr_o/mem_din_o = 0.
REQ-019 Sole requester is granted in the same cycle.
REQ-020 Both requesting, no lock: round-robin; the port not granted most recently wins; last_owner register resets to HOST so the CPU wins the first conflict.
REQ-021 FSM states IDLE, RR, LOCK; IDLE->RR on any request; RR->LOCK when host is granted with host_lock_i=1; LOCK->RR when host_lock_i=0, host_req_i=0, or lock counter reaches MAX_LOCK; RR->IDLE when no request.
REQ-022 In LOCK the host is granted every cycle it requests; the CPU is blocked; lock counter counts host grants, starting at 1 on entry.
REQ-023 On LOCK exit by counter expiry, the next conflict cycle grants the CPU regardless of host_lock_i; lock re-entry is allowed only after at least one CPU grant or one cycle without cpu_req_i.
REQ-024 Read latency: rvalid_o of the granted port asserts exactly one cycle after its read grant; rdata_o = mem_dout_i in that cycle, 0 otherwise; writes produce no rvalid.
REQ-025 A tagged owner register routes read data; back-to-back reads from alternating ports each return to the correct port.
REQ-026 Requesters hold req/addr/data stable until granted; the arbiter does not buffer ungranted requests.

Reset
REQ-027 During rst_ni=0: all grants, rvalid, mem_ren/wen = 0; rdata, mem_addr, mem_din = 0; FSM IDLE; last_owner HOST; lock counter 0; conflict_cnt_o 0.
REQ-028 Reset asserted mid-read cancels the pending rvalid; no rvalid is emitted after deassertion.

Configuration
REQ-029 Macro MEM_ARBITER_STATS_EN defined: conflict_cnt_o increments by 1 each cycle both req are high and one is stalled, saturating at 0xFFFF.
REQ-030 Macro undefined: the port exists, is tied to 0, and no counter flops are built.

Structure
REQ-031 Shared package angstrom_pkg holds ADDR_W/DATA_W defaults, owner typedef (OWN_CPU, OWN_HOST), and arbiter state typedef (ARB_IDLE, ARB_RR, ARB_LOCK).
REQ-032 One sub-module, rr_arb2: two-request round-robin picker with a last-owner input; mem_arbiter holds FSM, lock counter, read routing, and stats.

Verification
REQ-033 CPU only reads addr 0x010 holding 0x5A -> cpu_gnt_o same cycle, cpu_rvalid_o=1 with cpu_rdata_o=0x5A next cycle, host_* quiet.
REQ-034 Both request for 4 cycles, no lock -> grants CPU,HOST,CPU,HOST; conflict_cnt_o=4 with MEM_ARBITER_STATS_EN, 0 without.
REQ-035 Host writes 0x00..0x09 to 0x100..0x109 with lock held, CPU requesting, MAX_LOCK=8 -> 8 host grants, then 1 CPU grant, then host resumes.
REQ-036 Alternating CPU read 0x020 (0x11) / host read 0x030 (0x22) -> each rvalid on the correct port with correct data, no cross-delivery.
REQ-037 rst_ni pulled low the cycle after a CPU read grant -> no cpu_rvalid_o; all outputs 0; first conflict after release grants the CPU.

Source files
------------

// File: rtl/angstrom_pkg.sv
// ============================================================================
// Module   : angstrom_pkg
// Purpose  : Shared types and defaults for the data-RAM arbiter slice:
//            address/data width defaults, port-owner tag, arbiter states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package angstrom_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;
  localparam int LOCK_CNT_W = 8;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RR   = 2'd1,
    ARB_LOCK = 2'd2
  } arb_state_t;

  // The port that did not own the RAM most recently.
  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_CPU) ? OWN_HOST : OWN_CPU;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-request round-robin picker. A sole requester wins; on a
//            conflict the port that did not own the RAM last time wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import angstrom_pkg::*;
(
  input  logic req_cpu_i,
  input  logic req_host_i,
  input  logic last_owner_i,
  output logic gnt_cpu_o,
  output logic gnt_host_o
);

  owner_t w_pref;

  // Pick the sole requester, or the preferred port when both request.
  always_comb begin
    w_pref     = other_owner(owner_t'(last_owner_i));
    gnt_cpu_o  = 1'b0;
    gnt_host_o = 1'b0;
    if (req_cpu_i && req_host_i) begin
      gnt_cpu_o  = (w_pref == OWN_CPU);
      gnt_host_o = (w_pref == OWN_HOST);
    end else begin
      gnt_cpu_o  = req_cpu_i;
      gnt_host_o = req_host_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Single-port data-RAM arbiter between the CPU and a debug/loader
//            host. Combinational grant, round-robin on conflict, bounded host
//            lock, one-cycle read return routed by an owner tag.
//            Optional build macro MEM_ARBITER_STATS_EN enables the saturating
//            16-bit conflict counter; otherwise conflict_cnt_o is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import angstrom_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  input  logic              host_lock_i,
  output logic              host_gnt_o,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              mem_ren_o,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  input  logic [DATA_W-1:0] mem_dout_i,
  output logic [15:0]       conflict_cnt_o
);

  localparam logic [LOCK_CNT_W-1:0] LOCK_LIMIT = LOCK_CNT_W'(MAX_LOCK);

  arb_state_t            state_q, state_d;
  owner_t                last_owner_q, last_owner_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic                  cpu_owed_q, cpu_owed_d;   // CPU owed a turn after lock expiry
  logic                  rd_pend_q, rd_pend_d;
  owner_t                rd_owner_q, rd_owner_d;

  logic   w_in_lock;
  owner_t w_rr_last;
  logic   w_rr_cpu, w_rr_host;
  logic   w_cpu_gnt, w_host_gnt;
  logic   w_lock_start;

  assign w_in_lock = (state_q == ARB_LOCK);
  // After a lock expiry, present HOST as last owner so the CPU wins the next conflict.
  assign w_rr_last = cpu_owed_q ? OWN_HOST : last_owner_q;

  rr_arb2 u_rr_arb2 (
    .req_cpu_i    (cpu_req_i),
    .req_host_i   (host_req_i),
    .last_owner_i (w_rr_last),
    .gnt_cpu_o    (w_rr_cpu),
    .gnt_host_o   (w_rr_host)
  );

  // Grant: host owns the RAM outright while locked, otherwise round-robin.
  always_comb begin
    w_cpu_gnt  = 1'b0;
    w_host_gnt = 1'b0;
    if (w_in_lock) begin
      w_host_gnt = host_req_i;
    end else begin
      w_cpu_gnt  = w_rr_cpu;
      w_host_gnt = w_rr_host;
    end
  end

  // Grants and RAM port are forced quiet while reset is held.
  assign cpu_gnt_o  = w_cpu_gnt & rst_ni;
  assign host_gnt_o = w_host_gnt & rst_ni;

  // Steer the granted port onto the RAM; zero when nobody is granted.
  always_comb begin
    mem_ren_o  = 1'b0;
    mem_wen_o  = 1'b0;
    mem_addr_o = '0;
    mem_din_o  = '0;
    if (cpu_gnt_o) begin
      mem_ren_o  = ~cpu_we_i;
      mem_wen_o  = cpu_we_i;
      mem_addr_o = cpu_addr_i;
      mem_din_o  = cpu_wdata_i;
    end else if (host_gnt_o) begin
      mem_ren_o  = ~host_we_i;
      mem_wen_o  = host_we_i;
      mem_addr_o = host_addr_i;
      mem_din_o  = host_wdata_i;
    end
  end

  // Next-state: FSM, lock counter, last owner, CPU-owed flag, read tag.
  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    last_owner_d = last_owner_q;
    cpu_owed_d   = cpu_owed_q;
    rd_pend_d    = (w_cpu_gnt & ~cpu_we_i) | (w_host_gnt & ~host_we_i);
    rd_owner_d   = w_host_gnt ? OWN_HOST : OWN_CPU;

    if (w_cpu_gnt) begin
      last_owner_d = OWN_CPU;
    end else if (w_host_gnt) begin
      last_owner_d = OWN_HOST;
    end

    // The debt is paid by a CPU grant or forgiven by a cycle without a CPU request.
    if (w_cpu_gnt || !cpu_req_i) begin
      cpu_owed_d = 1'b0;
    end

    // The grant that starts a lock is the first of the MAX_LOCK it may take.
    w_lock_start = w_host_gnt & host_lock_i & ~w_in_lock & (~cpu_owed_q | ~cpu_req_i);

    case (state_q)
      ARB_IDLE, ARB_RR: begin
        if (w_lock_start) begin
          if (LOCK_LIMIT <= 8'd1) begin
            state_d    = ARB_RR;
            lock_cnt_d = '0;
            cpu_owed_d = 1'b1;
          end else begin
            state_d    = ARB_LOCK;
            lock_cnt_d = 8'd1;
          end
        end else if (cpu_req_i || host_req_i) begin
          state_d = ARB_RR;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_LOCK: begin
        if (w_host_gnt && host_lock_i) begin
          if (lock_cnt_q == LOCK_LIMIT - 8'd1) begin
            state_d    = ARB_RR;
            lock_cnt_d = '0;
            cpu_owed_d = 1'b1;
          end else begin
            lock_cnt_d = lock_cnt_q + 8'd1;
          end
        end else begin
          state_d    = ARB_RR;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ARB_IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // State registers; reset also cancels any read in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= OWN_HOST;
      lock_cnt_q   <= '0;
      cpu_owed_q   <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= OWN_CPU;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      cpu_owed_q   <= cpu_owed_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // Read return goes to whichever port issued the read last cycle.
  assign cpu_rvalid_o  = rd_pend_q & (rd_owner_q == OWN_CPU);
  assign host_rvalid_o = rd_pend_q & (rd_owner_q == OWN_HOST);
  assign cpu_rdata_o   = cpu_rvalid_o  ? mem_dout_i : '0;
  assign host_rdata_o  = host_rvalid_o ? mem_dout_i : '0;

`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] conflict_cnt_q;

  // Count cycles where both ports request (one is necessarily stalled), saturating.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt_q <= '0;
    end else if (cpu_req_i && host_req_i && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_q <= conflict_cnt_q + 16'd1;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
`else
  assign conflict_cnt_o = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: directed vector table,
//            reset / lock / routing sequences and randomized traffic checked
//            against a grant-history reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int ML = 8;
`ifdef MEM_ARBITER_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [AW-1:0] cpu_addr_i = '0;
  logic [DW-1:0] cpu_wdata_i = '0;
  logic          cpu_gnt_o, cpu_rvalid_o;
  logic [DW-1:0] cpu_rdata_o;
  logic          host_req_i = 1'b0, host_we_i = 1'b0, host_lock_i = 1'b0;
  logic [AW-1:0] host_addr_i = '0;
  logic [DW-1:0] host_wdata_i = '0;
  logic          host_gnt_o, host_rvalid_o;
  logic [DW-1:0] host_rdata_o;
  logic          mem_ren_o, mem_wen_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_din_o;
  logic [DW-1:0] mem_dout_i;
  logic [15:0]   conflict_cnt_o;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o),
    .cpu_rdata_o(cpu_rdata_o),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_wdata_i(host_wdata_i), .host_lock_i(host_lock_i), .host_gnt_o(host_gnt_o),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
    .mem_ren_o(mem_ren_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_din_o(mem_din_o), .mem_dout_i(mem_dout_i), .conflict_cnt_o(conflict_cnt_o)
  );

  // Power-on RAM contents (also the reference model's starting picture).
  function automatic logic [7:0] init_val(input logic [AW-1:0] a);
    int t;
    case (a)
      12'h010: return 8'h5A;
      12'h020: return 8'h11;
      12'h030: return 8'h22;
      default: begin
        t = int'(a) * 37 + 5;
        return t[7:0];
      end
    endcase
  endfunction

  // Behavioural single-port RAM with one-cycle read latency.
  logic [7:0] ram   [0:4095];
  bit         ram_v [0:4095];
  always @(posedge clk_i) begin
    if (mem_wen_o) begin
      ram[mem_addr_o]   <= mem_din_o;
      ram_v[mem_addr_o] <= 1'b1;
    end
    if (mem_ren_o) mem_dout_i <= ram_v[mem_addr_o] ? ram[mem_addr_o] : init_val(mem_addr_o);
  end

  // ---------------- reference model ----------------
  int         m_streak;     // consecutive host grants taken under lock, 0 = not locked
  bit         m_owe;        // CPU owed the next conflict after a lock ran out
  bit         m_last_host;  // most recent grant went to host
  bit         m_pend, m_pend_host;
  logic [7:0] m_pend_data;
  int         m_conf;
  logic [7:0] shadow   [0:4095];
  bit         shadow_v [0:4095];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  function automatic logic [7:0] mread(input logic [AW-1:0] a);
    return shadow_v[a] ? shadow[a] : init_val(a);
  endfunction

  task automatic model_reset();
    m_streak = 0; m_owe = 0; m_last_host = 1; m_pend = 0; m_pend_host = 0;
    m_pend_data = '0; m_conf = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    bit            cr, cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    bit            hr, hw, hl;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
  } in_t;

  typedef struct {
    in_t           i;
    bit            ecg, ehg, ecv, ehv;
    logic [DW-1:0] ecd, ehd;
  } vec_t;

  // One clock cycle: entered and left 1ns after a rising edge.
  task automatic do_cycle(input in_t v, output bit acg, output bit ahg);
    bit            ecg, ehg, eren, ewen, ecv, ehv;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edin, ecd, ehd;
    cpu_req_i = v.cr; cpu_we_i = v.cw; cpu_addr_i = v.ca; cpu_wdata_i = v.cd;
    host_req_i = v.hr; host_we_i = v.hw; host_lock_i = v.hl;
    host_addr_i = v.ha; host_wdata_i = v.hd;

    if (m_streak > 0) begin
      ecg = 0; ehg = v.hr;
    end else if (v.cr && v.hr) begin
      ecg = m_owe || m_last_host; ehg = !ecg;
    end else begin
      ecg = v.cr; ehg = v.hr;
    end
    eren  = (ecg && !v.cw) || (ehg && !v.hw);
    ewen  = (ecg && v.cw) || (ehg && v.hw);
    eaddr = ecg ? v.ca : (ehg ? v.ha : '0);
    edin  = ecg ? v.cd : (ehg ? v.hd : '0);
    ecv   = m_pend && !m_pend_host;
    ehv   = m_pend && m_pend_host;
    ecd   = ecv ? m_pend_data : '0;
    ehd   = ehv ? m_pend_data : '0;

    @(negedge clk_i);
    chk("cpu_gnt", cpu_gnt_o, ecg);
    chk("host_gnt", host_gnt_o, ehg);
    chk("mem_ren", mem_ren_o, eren);
    chk("mem_wen", mem_wen_o, ewen);
    chk("mem_addr", mem_addr_o, eaddr);
    chk("mem_din", mem_din_o, edin);
    chk("cpu_rvalid", cpu_rvalid_o, ecv);
    chk("cpu_rdata", cpu_rdata_o, ecd);
    chk("host_rvalid", host_rvalid_o, ehv);
    chk("host_rdata", host_rdata_o, ehd);
    chk("conflict_cnt", conflict_cnt_o, (STATS != 0) ? m_conf : 0);
    acg = cpu_gnt_o;
    ahg = host_gnt_o;

    if (ecg || ehg) m_last_host = ehg;
    m_pend = eren; m_pend_host = ehg;
    if (eren) m_pend_data = mread(eaddr);
    if (ewen) begin shadow[eaddr] = edin; shadow_v[eaddr] = 1; end
    if (v.cr && v.hr && m_conf < 65535) m_conf++;
    if (ecg || !v.cr) m_owe = 0;
    if (m_streak > 0) begin
      if (ehg && v.hl) begin
        m_streak++;
        if (m_streak >= ML) begin m_streak = 0; m_owe = 1; end
      end else begin
        m_streak = 0;
      end
    end else if (ehg && v.hl && !m_owe) begin
      m_streak = 1;
      if (m_streak >= ML) begin m_streak = 0; m_owe = 1; end
    end

    @(posedge clk_i); #1;
    cyc++;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_cpu_gnt"}, cpu_gnt_o, 0);
    chk({tag, "_host_gnt"}, host_gnt_o, 0);
    chk({tag, "_ren_wen"}, {mem_ren_o, mem_wen_o}, 0);
    chk({tag, "_mem_addr"}, mem_addr_o, 0);
    chk({tag, "_mem_din"}, mem_din_o, 0);
    chk({tag, "_rvalid"}, {cpu_rvalid_o, host_rvalid_o}, 0);
    chk({tag, "_rdata"}, {cpu_rdata_o, host_rdata_o}, 0);
    chk({tag, "_conflict"}, conflict_cnt_o, 0);
  endtask

  function automatic in_t mk(input bit cr, input bit cw, input logic [AW-1:0] ca,
                             input logic [DW-1:0] cd, input bit hr, input bit hw,
                             input bit hl, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    in_t r;
    r.cr = cr; r.cw = cw; r.ca = ca; r.cd = cd;
    r.hr = hr; r.hw = hw; r.hl = hl; r.ha = ha; r.hd = hd;
    return r;
  endfunction

  function automatic vec_t mv(input in_t i, input bit ecg, input bit ehg, input bit ecv,
                              input logic [DW-1:0] ecd, input bit ehv, input logic [DW-1:0] ehd);
    vec_t r;
    r.i = i; r.ecg = ecg; r.ehg = ehg; r.ecv = ecv; r.ecd = ecd; r.ehv = ehv; r.ehd = ehd;
    return r;
  endfunction

  initial begin
    vec_t tbl [10];
    in_t  idle, both_rd, v;
    bit   acg, ahg;
    int   hi, n_host_before, first_cpu;
    bit   c_pend, h_pend;
    in_t  cur;

    idle    = mk(0, 0, 12'h000, 8'h00, 0, 0, 0, 12'h000, 8'h00);
    both_rd = mk(1, 0, 12'h020, 8'h00, 1, 0, 0, 12'h030, 8'h00);
    tbl[0] = mv(both_rd, 1, 0, 0, 8'h00, 0, 8'h00);
    tbl[1] = mv(both_rd, 0, 1, 1, 8'h11, 0, 8'h00);
    tbl[2] = mv(both_rd, 1, 0, 0, 8'h00, 1, 8'h22);
    tbl[3] = mv(both_rd, 0, 1, 1, 8'h11, 0, 8'h00);
    tbl[4] = mv(idle,    0, 0, 0, 8'h00, 1, 8'h22);
    tbl[5] = mv(mk(1, 0, 12'h010, 8'h00, 0, 0, 0, 12'h000, 8'h00), 1, 0, 0, 8'h00, 0, 8'h00);
    tbl[6] = mv(idle,    0, 0, 1, 8'h5A, 0, 8'h00);
    tbl[7] = mv(mk(0, 0, 12'h000, 8'h00, 1, 1, 0, 12'h040, 8'h77), 0, 1, 0, 8'h00, 0, 8'h00);
    tbl[8] = mv(mk(1, 0, 12'h040, 8'h00, 0, 0, 0, 12'h000, 8'h00), 1, 0, 0, 8'h00, 0, 8'h00);
    tbl[9] = mv(idle,    0, 0, 1, 8'h77, 0, 8'h00);

    // Reset state with both ports requesting.
    model_reset();
    cpu_req_i = 1; host_req_i = 1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk_quiet("reset");
    @(posedge clk_i); #1;
    rst_ni = 1;

    // Directed table: conflicts, alternating read routing, CPU read, write then read.
    for (int k = 0; k < 10; k++) begin
      cpu_req_i = 0;
      do_cycle(tbl[k].i, acg, ahg);
      chk($sformatf("tbl%0d_cpu_gnt", k), cpu_gnt_o === 1'bx ? 0 : acg, tbl[k].ecg);
      chk($sformatf("tbl%0d_host_gnt", k), ahg, tbl[k].ehg);
      if (k == 4) chk("conflict_after_4", conflict_cnt_o, (STATS != 0) ? 4 : 0);
    end

    // Reset asserted mid-read: the pending CPU read must never return.
    do_cycle(mk(1, 0, 12'h010, 8'h00, 0, 0, 0, 12'h000, 8'h00), acg, ahg);
    rst_ni = 0;
    cpu_req_i = 1; host_req_i = 1;
    #1;
    chk("rst_mid_cpu_rvalid", cpu_rvalid_o, 0);
    @(negedge clk_i);
    chk_quiet("rst_mid");
    @(posedge clk_i); #1;
    rst_ni = 1;
    model_reset();
    do_cycle(idle, acg, ahg);
    chk("post_rst_no_rvalid", cpu_rvalid_o, 0);
    do_cycle(both_rd, acg, ahg);
    chk("post_rst_first_conflict_cpu", acg, 1);

    // Host lock burst against a continuously requesting CPU.
    hi = 0; n_host_before = 0; first_cpu = -1;
    for (int k = 0; k < 12; k++) begin
      v = mk(1, 0, 12'h010, 8'h00, hi < 10, 1, 1, 12'h100 + 12'(hi), 8'(hi));
      do_cycle(v, acg, ahg);
      if (acg && first_cpu < 0) first_cpu = k;
      if (ahg && first_cpu < 0) n_host_before++;
      if (k == 9) chk("lock_host_resumes", ahg, 1);
      if (ahg) hi++;
    end
    chk("lock_host_grants_before_cpu", n_host_before, ML);
    chk("lock_cpu_slot", first_cpu, ML);
    do_cycle(idle, acg, ahg);
    for (int a = 0; a < 10; a++) chk($sformatf("lock_wr_%0d", a), ram[12'h100 + 12'(a)], a);

    // Randomized traffic; requesters hold until granted.
    c_pend = 0; h_pend = 0; cur = idle;
    for (int k = 0; k < 600; k++) begin
      if (!c_pend && ($urandom_range(0, 9) < 6)) begin
        c_pend = 1; cur.cw = $urandom_range(0, 1);
        cur.ca = 12'h200 + 12'($urandom_range(0, 31)); cur.cd = 8'($urandom);
      end
      if (!h_pend && ($urandom_range(0, 9) < 6)) begin
        h_pend = 1; cur.hw = $urandom_range(0, 1);
        cur.ha = 12'h200 + 12'($urandom_range(0, 31)); cur.hd = 8'($urandom);
      end
      cur.cr = c_pend; cur.hr = h_pend;
      cur.hl = ($urandom_range(0, 3) != 0);
      do_cycle(cur, acg, ahg);
      if (acg) c_pend = 0;
      if (ahg) h_pend = 0;
    end
    do_cycle(idle, acg, ahg);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
